div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for the EX stage.
- Consumes the 8-bit alucontrol code from the ALU decoder and executes EXE_DIV_OP (signed) and EXE_DIVU_OP (unsigned).
- Raises a pipeline stall request while busy, then presents {hi, lo} = {remainder, quotient} for the HI/LO register write.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit_step.sv | 29 ++
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared ALU op codes and FSM state encoding for the EX-stage divider.
package div_unit_pkg;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DZERO = 2'b10,
    DONE  = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [7:0]         alucontrol;
  logic               start;
  logic               annul;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall_req;

  modport master (
    output alucontrol, start, annul, a, b,
    input  result, ready, stall_req
  );

  modport slave (
    input  alucontrol, start, annul, a, b,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < dvs always holds, so the shifted remainder fits in WIDTH+1 bits and
  // diff[WIDTH] is exactly the borrow of the trial subtraction.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    if (diff[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               go;
  logic               is_signed;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    go        = bus.start & ~bus.annul & is_div_op(bus.alucontrol);
    is_signed = (bus.alucontrol == EXE_DIV_OP);

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          if (bus.b != '0) begin
            state_d = BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
            dvs_d   = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
            qneg_d  = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg_d  = is_signed & bus.a[WIDTH-1];
          end else begin
            // Dividend parks in rem_q so DZERO can report it without sign fixup.
            state_d = DZERO;
            rem_d   = bus.a;
          end
        end
      end
      BUSY: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {rneg_q ? -step_rem : step_rem,
                        qneg_q ? -step_quo : step_quo};
          end
        end
      end
      DZERO: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = {rem_q, {WIDTH{1'b1}}};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.ready     = ready_q;
  assign bus.stall_req = ((state_q == IDLE) & go) | (state_q == BUSY) | (state_q == DZERO);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed/unsigned results, latency, stall, divide-by-zero, annul, reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;
  logic [63:0] last_res;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Issues one op at the current cycle T and follows it to its ready pulse.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input int exp_lat, input logic [63:0] exp_res);
    int   lat;
    int   stalls;
    logic stall_at_ready;
    lat            = 0;
    stalls         = 0;
    stall_at_ready = 1'b1;
    bus.alucontrol = op;
    bus.a          = av;
    bus.b          = bv;
    bus.start      = 1'b1;
    #1;
    if (bus.stall_req) stalls++;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
      end
      if (bus.ready) begin
        lat            = k;
        stall_at_ready = bus.stall_req;
      end else if (bus.stall_req) begin
        stalls++;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    chk({tag, "_stall_on_ready"}, 64'(stall_at_ready), 64'd0);
    chk({tag, "_result"}, bus.result, exp_res);
    @(posedge clk); #1;
    chk({tag, "_ready_pulse"}, 64'(bus.ready), 64'd0);
    chk({tag, "_result_held"}, bus.result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rdy_cnt;
    int stl_cnt;
    n_tests        = 0;
    n_fail         = 0;
    last_res       = '0;
    resetn         = 1'b0;
    bus.alucontrol = '0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    bus.a          = '0;
    bus.b          = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", bus.result, 64'h0);
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_stall", 64'(bus.stall_req), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_div("divu_7_2",     EXE_DIVU_OP, 32'd7,         32'd2,         33, {32'h1, 32'h3});
    run_div("div_m7_2",     EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,         33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_ovf",      EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
    run_div("div_100_m7",   EXE_DIV_OP,  32'd100,       32'hFFFF_FFF9, 33, {32'h2, 32'hFFFF_FFF2});
    run_div("divu_max_m1",  EXE_DIVU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, {32'h1, 32'h1});
    run_div("divu_max_1",   EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1,         33, {32'h0, 32'hFFFF_FFFF});
    run_div("divu_by_zero", EXE_DIVU_OP, 32'h0000_1234, 32'h0,          2, {32'h0000_1234, 32'hFFFF_FFFF});
    run_div("div_by_zero",  EXE_DIV_OP,  32'h8000_0000, 32'h0,          2, {32'h8000_0000, 32'hFFFF_FFFF});

    // Annul partway through a divide.
    bus.alucontrol = EXE_DIVU_OP;
    bus.a          = 32'd100;
    bus.b          = 32'd5;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    #1;
    chk("annul_stall_same_cycle", 64'(bus.stall_req), 64'd1);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    #1;
    chk("annul_stall_next", 64'(bus.stall_req), 64'd0);
    rdy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.ready) rdy_cnt++;
      @(posedge clk); #1;
    end
    chk("annul_no_ready", 64'(rdy_cnt), 64'd0);
    chk("annul_result_kept", bus.result, last_res);
    run_div("divu_9_3", EXE_DIVU_OP, 32'd9, 32'd3, 33, {32'h0, 32'h3});

    // Reset partway through a divide.
    bus.alucontrol = EXE_DIVU_OP;
    bus.a          = 32'd1000;
    bus.b          = 32'd7;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("midreset_result", bus.result, 64'h0);
    chk("midreset_ready", 64'(bus.ready), 64'd0);
    chk("midreset_stall", 64'(bus.stall_req), 64'd0);
    @(posedge clk); #1;
    resetn   = 1'b1;
    last_res = '0;
    rdy_cnt  = 0;
    stl_cnt  = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.ready) rdy_cnt++;
      if (bus.stall_req) stl_cnt++;
    end
    chk("midreset_no_ready", 64'(rdy_cnt), 64'd0);
    chk("midreset_idle", 64'(stl_cnt), 64'd0);

    // Non-divide op must be ignored.
    bus.alucontrol = EXE_ADD_OP;
    bus.a          = 32'd10;
    bus.b          = 32'd2;
    bus.start      = 1'b1;
    #1;
    chk("add_stall_now", 64'(bus.stall_req), 64'd0);
    rdy_cnt = 0;
    stl_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.ready) rdy_cnt++;
      if (bus.stall_req) stl_cnt++;
    end
    bus.start = 1'b0;
    chk("add_no_ready", 64'(rdy_cnt), 64'd0);
    chk("add_no_stall", 64'(stl_cnt), 64'd0);
    chk("add_result_kept", bus.result, last_res);

    run_div("div_after_add", EXE_DIV_OP, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'h0000_000E});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
